// File: rtl/aes_cbc_chain.sv
// AES-128 CBC chaining wrapper around an external combinational AES core.
// Define AES_CBC_BLKCNT_EN to add the blk_cnt ciphertext block counter output.
module aes_cbc_chain #(
    parameter  int unsigned CORE_LAT = 1,
    localparam int unsigned BLK_W    = 128,
    localparam int unsigned BCNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             iv_load,
    input  logic [BLK_W-1:0] iv_in,
    input  logic [BLK_W-1:0] key_in,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BLK_W-1:0] s_data,
    output logic [BLK_W-1:0] core_in,
    output logic [BLK_W-1:0] core_key,
    input  logic [BLK_W-1:0] core_out,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BLK_W-1:0] m_data
`ifdef AES_CBC_BLKCNT_EN
    ,
    output logic [BCNT_W-1:0] blk_cnt
`endif
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        OUT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [BLK_W-1:0] chain_q, chain_d;
    logic [BLK_W-1:0] core_in_q, core_in_d;
    logic [BLK_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] m_data_q, m_data_d;
    logic             m_valid_q, m_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef AES_CBC_BLKCNT_EN
    logic [BCNT_W-1:0] blk_cnt_q, blk_cnt_d;
`endif

    // Next-state logic; core_in/core_key only move on IV load or block accept
    always_comb begin
        state_d   = state_q;
        chain_d   = chain_q;
        core_in_d = core_in_q;
        key_d     = key_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        cnt_d     = cnt_q;
`ifdef AES_CBC_BLKCNT_EN
        blk_cnt_d = blk_cnt_q;
`endif
        s_ready   = (state_q == IDLE) && !iv_load;

        case (state_q)
            IDLE: begin
                if (iv_load) begin
                    chain_d = iv_in;
                    key_d   = key_in;
`ifdef AES_CBC_BLKCNT_EN
                    blk_cnt_d = '0;
`endif
                end else if (s_valid) begin
                    core_in_d = s_data ^ chain_q;
                    cnt_d     = CNT_W'(CORE_LAT - 1);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    m_data_d  = core_out;
                    m_valid_d = 1'b1;
                    state_d   = OUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            OUT: begin
                // Ciphertext becomes the chain value once downstream takes it
                if (m_ready) begin
                    chain_d   = m_data_q;
                    m_valid_d = 1'b0;
                    state_d   = IDLE;
`ifdef AES_CBC_BLKCNT_EN
                    blk_cnt_d = blk_cnt_q + BCNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            chain_q   <= '0;
            core_in_q <= '0;
            key_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            cnt_q     <= '0;
`ifdef AES_CBC_BLKCNT_EN
            blk_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            chain_q   <= chain_d;
            core_in_q <= core_in_d;
            key_q     <= key_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            cnt_q     <= cnt_d;
`ifdef AES_CBC_BLKCNT_EN
            blk_cnt_q <= blk_cnt_d;
`endif
        end
    end

    assign core_in  = core_in_q;
    assign core_key = key_q;
    assign m_data   = m_data_q;
    assign m_valid  = m_valid_q;
`ifdef AES_CBC_BLKCNT_EN
    assign blk_cnt  = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_cbc_chain.sv
// Self-checking bench for aes_cbc_chain: behavioural AES-128 core with latency, known vectors,
// corner sequences and randomized CBC traffic against a reference model.
module tb_aes_cbc_chain;
    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic         clk;
    logic         rst;
    logic         iv_load, iv_load_b;
    logic [127:0] iv_in, key_in;
    logic         s_valid, s_valid_b;
    logic         s_ready, s_ready_b;
    logic [127:0] s_data, s_data_b;
    logic [127:0] core_in, core_in_b, core_key, core_key_b, core_out, core_out_b;
    logic         m_valid, m_valid_b;
    logic         m_ready, m_ready_b;
    logic [127:0] m_data, m_data_b;
`ifdef AES_CBC_BLKCNT_EN
    logic [31:0]  blk_cnt, blk_cnt_b;
`endif

    aes_cbc_chain #(.CORE_LAT(LAT_A)) u_dut_a (
        .clk(clk), .rst(rst), .iv_load(iv_load), .iv_in(iv_in), .key_in(key_in),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .core_in(core_in), .core_key(core_key), .core_out(core_out),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef AES_CBC_BLKCNT_EN
        , .blk_cnt(blk_cnt)
`endif
    );

    aes_cbc_chain #(.CORE_LAT(LAT_B)) u_dut_b (
        .clk(clk), .rst(rst), .iv_load(iv_load_b), .iv_in(iv_in), .key_in(key_in),
        .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data_b),
        .core_in(core_in_b), .core_key(core_key_b), .core_out(core_out_b),
        .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b)
`ifdef AES_CBC_BLKCNT_EN
        , .blk_cnt(blk_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // ---------------- behavioural AES-128 ----------------
    logic [7:0] sbox [256];
    logic [7:0] inv_t;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] key);
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [7:0]   rk [16];
        logic [7:0]   rcon = 8'h01;
        logic [7:0]   t0, t1, t2, t3, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            rk[i] = key[127-8*i -: 8];
            st[i] = pt[127-8*i -: 8] ^ rk[i];
        end
        for (int rnd = 1; rnd <= 10; rnd++) begin
            t0 = sbox[rk[13]] ^ rcon;
            t1 = sbox[rk[14]];
            t2 = sbox[rk[15]];
            t3 = sbox[rk[12]];
            rk[0] = rk[0] ^ t0; rk[1] = rk[1] ^ t1; rk[2] = rk[2] ^ t2; rk[3] = rk[3] ^ t3;
            for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
            rcon = xt(rcon);
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    tmp[r+4*c] = sbox[st[r + 4*((c+r)%4)]];
            for (int c = 0; c < 4; c++) begin
                a0 = tmp[4*c]; a1 = tmp[4*c+1]; a2 = tmp[4*c+2]; a3 = tmp[4*c+3];
                if (rnd != 10) begin
                    st[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    st[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    st[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    st[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) st[i] = st[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Core model: correct ciphertext only after its inputs have been stable CORE_LAT cycles
    logic [127:0] lin_a = '0, lkey_a = '0, good_a = '0;
    logic [127:0] lin_b = '0, lkey_b = '0, good_b = '0;
    int stab_a = 0, stab_b = 0;
    initial begin
        core_out   = '0;
        core_out_b = '0;
    end
    always @(posedge clk) begin
        #1;
        if (core_in !== lin_a || core_key !== lkey_a) begin
            lin_a = core_in; lkey_a = core_key; good_a = aes_enc(core_in, core_key); stab_a = 1;
        end else if (stab_a < 1000) stab_a++;
        core_out = (stab_a >= LAT_A) ? good_a : ~good_a;
        if (core_in_b !== lin_b || core_key_b !== lkey_b) begin
            lin_b = core_in_b; lkey_b = core_key_b; good_b = aes_enc(core_in_b, core_key_b); stab_b = 1;
        end else if (stab_b < 1000) stab_b++;
        core_out_b = (stab_b >= LAT_B) ? good_b : ~good_b;
    end

    // Push one block through DUT A, optionally holding m_ready low while spamming iv_load
    task automatic xfer_a(input logic [127:0] pt, input int hold,
                          output logic [127:0] ct, output int waits, output int lat);
        logic [127:0] first;
        @(negedge clk);
        iv_load = 1'b0; s_valid = 1'b1; s_data = pt; m_ready = 1'b0;
        #1;
        waits = 0;
        while (!s_ready && waits < 50) begin
            @(negedge clk); #1; waits++;
        end
        @(negedge clk);
        s_valid = 1'b0; s_data = '0; lat = 1;
        #1;
        while (!m_valid && lat < 50) begin
            @(negedge clk); #1; lat++;
        end
        first = m_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            iv_load = 1'b0;
            #1;
            chk1("hold_s_ready", s_ready, 1'b0);
            chk1("hold_m_valid", m_valid, 1'b1);
            chk("hold_m_data", m_data, first);
            iv_load = 1'b1; iv_in = rnd128(); key_in = rnd128();
        end
        @(negedge clk);
        iv_load = 1'b0; m_ready = 1'b1;
        #1;
        ct = m_data;
        @(negedge clk);
        m_ready = 1'b0;
        #1;
        chk1("next_s_ready", s_ready, 1'b1);
    endtask

    typedef struct {
        logic         load;
        logic [127:0] key;
        logic [127:0] iv;
        logic [127:0] pt;
        int           hold;
        logic [127:0] ct;
    } vec_t;
    vec_t vecs [3];

    logic [127:0] ct, exp_ct, chain_m, key_m;
    logic [31:0]  blk_m;
    logic         busy_m, exp_mv;
    int           waits, lat, age;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int x = 0; x < 256; x++) begin
            inv_t = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv_t = 8'(y);
            sbox[x] = inv_t ^ rotl(inv_t, 1) ^ rotl(inv_t, 2) ^ rotl(inv_t, 3) ^ rotl(inv_t, 4) ^ 8'h63;
        end

        vecs[0] = '{1'b1, 128'h000102030405060708090a0b0c0d0e0f, 128'h0,
                    128'h00112233445566778899aabbccddeeff, 0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[1] = '{1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h6bc1bee22e409f96e93d7e117393172a, 10, 128'h7649abac8119b246cee98e9b12e9197d};
        vecs[2] = '{1'b0, 128'h0, 128'h0,
                    128'hae2d8a571e03ac9c9eb76fac45af8e51, 0, 128'h5086cb9b507219ee95db113a917678b2};

        rst = 1'b1; iv_load = 1'b0; iv_in = '0; key_in = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        iv_load_b = 1'b0; s_valid_b = 1'b0; s_data_b = '0; m_ready_b = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk1("rst_s_ready", s_ready, 1'b1);
        chk1("rst_m_valid", m_valid, 1'b0);
        chk("rst_core_in", core_in, 128'h0);
        chk("rst_core_key", core_key, 128'h0);
        chk("rst_m_data", m_data, 128'h0);
        rst = 1'b0;

        // Known-answer vectors, including backpressure with ignored iv_load on P1
        for (int v = 0; v < 3; v++) begin
            if (vecs[v].load) begin
                @(negedge clk);
                iv_load = 1'b1; iv_in = vecs[v].iv; key_in = vecs[v].key;
                #1;
                chk1("load_s_ready", s_ready, 1'b0);
            end
            xfer_a(vecs[v].pt, vecs[v].hold, ct, waits, lat);
            chk("vec_ct", ct, vecs[v].ct);
            chk("vec_latency", 128'(lat), 128'(LAT_A + 1));
        end
`ifdef AES_CBC_BLKCNT_EN
        chk("blk_cnt_two", 128'(blk_cnt), 128'd2);
`endif

        // iv_load and s_valid together: load wins, block taken the following cycle
        @(negedge clk);
        iv_load = 1'b1; iv_in = vecs[1].iv; key_in = vecs[1].key; s_valid = 1'b1; s_data = vecs[1].pt;
        #1;
        chk1("simul_s_ready", s_ready, 1'b0);
        xfer_a(vecs[1].pt, 0, ct, waits, lat);
        chk("simul_waits", 128'(waits), 128'd0);
        chk("simul_ct", ct, vecs[1].ct);
`ifdef AES_CBC_BLKCNT_EN
        chk("blk_cnt_reload", 128'(blk_cnt), 128'd1);
`endif

        // CORE_LAT=1 instance latency
        @(negedge clk);
        iv_load_b = 1'b1; iv_in = 128'h0; key_in = vecs[0].key;
        @(negedge clk);
        iv_load_b = 1'b0; s_valid_b = 1'b1; s_data_b = vecs[0].pt;
        #1;
        chk1("b_s_ready", s_ready_b, 1'b1);
        @(negedge clk);
        s_valid_b = 1'b0; lat = 1;
        #1;
        while (!m_valid_b && lat < 50) begin
            @(negedge clk); #1; lat++;
        end
        chk("b_latency", 128'(lat), 128'(LAT_B + 1));
        chk("b_ct", m_data_b, vecs[0].ct);
        m_ready_b = 1'b1;
        @(negedge clk);
        m_ready_b = 1'b0;

        // Reset while BUSY aborts the block
        @(negedge clk);
        s_valid = 1'b1; s_data = rnd128(); m_ready = 1'b1;
        #1;
        chk1("rb_accept", s_ready, 1'b1);
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk1("rb_busy", s_ready, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
        chk1("rb_m_valid", m_valid, 1'b0);
        chk("rb_core_in", core_in, 128'h0);
        chk("rb_core_key", core_key, 128'h0);
        chk1("rb_s_ready", s_ready, 1'b1);
`ifdef AES_CBC_BLKCNT_EN
        chk("rb_blk_cnt", 128'(blk_cnt), 128'd0);
`endif
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk1("rb_no_output", m_valid, 1'b0);
        end
        m_ready = 1'b0;

        // Randomized CBC traffic against a transaction-level model
        chain_m = '0; key_m = '0; blk_m = '0; busy_m = 1'b0; age = 0; exp_ct = '0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            @(negedge clk);
            iv_load = ($urandom_range(0, 15) == 0);
            iv_in   = rnd128();
            key_in  = rnd128();
            s_valid = ($urandom_range(0, 1) == 1);
            s_data  = rnd128();
            m_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_mv = busy_m && (age >= LAT_A + 1);
            chk1("rnd_s_ready", s_ready, !busy_m && !iv_load);
            chk1("rnd_m_valid", m_valid, exp_mv);
            chk("rnd_core_key", core_key, key_m);
`ifdef AES_CBC_BLKCNT_EN
            chk("rnd_blk_cnt", 128'(blk_cnt), 128'(blk_m));
`endif
            if (exp_mv) chk("rnd_m_data", m_data, exp_ct);
            if (exp_mv && m_ready) begin
                chain_m = exp_ct; busy_m = 1'b0; blk_m = blk_m + 32'd1;
            end else if (!busy_m && iv_load) begin
                chain_m = iv_in; key_m = key_in; blk_m = '0;
            end else if (!busy_m && s_valid) begin
                exp_ct = aes_enc(s_data ^ chain_m, key_m); busy_m = 1'b1; age = 0;
            end
            if (busy_m) age++;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/aes_cbc_chain.md
AES_CBC_CHAIN -- requirements
Module: aes_cbc_chain

Interface
REQ-001 The block SHALL have parameter CORE_LAT, default 1: number of cycles (1..15) between core_in/core_key becoming stable and sampling core_out.
REQ-002 The block SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 The block SHALL have port iv_load, input, 1: request to load a new IV and key.
REQ-005 The block SHALL have port iv_in, input, 128: initialisation vector.
REQ-006 The block SHALL have port key_in, input, 128: AES-128 cipher key.
REQ-007 The block SHALL have port s_valid, input, 1: plaintext block valid.
REQ-008 The block SHALL have port s_ready, output, 1: plaintext block accepted when high together with s_valid.
REQ-009 The block SHALL have port s_data, input, 128: plaintext block.
REQ-010 The block SHALL have port core_in, output, 128: registered plaintext XOR chain value, driven to the combinational encryption core data input.
REQ-011 The block SHALL have port core_key, output, 128: registered key, driven to the core key input.
REQ-012 The block SHALL have port core_out, input, 128: ciphertext returned by the core.
REQ-013 The block SHALL have port m_valid, output, 1: ciphertext valid.
REQ-014 The block SHALL have port m_ready, input, 1: downstream accepts ciphertext.
REQ-015 The block SHALL have port m_data, output, 128: ciphertext block.

Function
REQ-016 The FSM SHALL have the states IDLE, BUSY and OUT.
REQ-017 s_ready SHALL equal (state==IDLE) && !iv_load, combinationally.
REQ-018 In IDLE with iv_load=1: chain<=iv_in and core_key<=key_in; the state SHALL remain IDLE; iv_load SHALL win over a simultaneous s_valid.
REQ-019 In IDLE on s_valid&&s_ready: core_in<=s_data^chain, cnt<=CORE_LAT-1, state<=BUSY.
REQ-020 In BUSY: cnt SHALL decrement each cycle; when cnt==0, m_data<=core_out, m_valid<=1, state<=OUT.
REQ-021 Latency: with the accept handshake in cycle T, m_valid SHALL first be high in cycle T+CORE_LAT+1.
REQ-022 In OUT: m_valid and m_data SHALL hold stable until m_valid&&m_ready.
REQ-023 On m_valid&&m_ready: chain<=m_data, m_valid<=0, state<=IDLE; the next block SHALL be acceptable in the following cycle.
REQ-024 iv_load in BUSY or OUT SHALL be ignored and not remembered; chain and core_key SHALL be unchanged.
REQ-025 core_in and core_key SHALL change only at the events in REQ-018 and REQ-019, giving the core CORE_LAT stable cycles.
REQ-026 Throughput SHALL be at most one block per CORE_LAT+2 cycles; no pipelining of multiple blocks.
REQ-027 All XOR operations SHALL be full 128-bit bitwise, with bit 127 the first byte MSB.

Reset
REQ-028 rst=1 at a clock edge SHALL set state=IDLE, chain=0, core_in=0, core_key=0, m_data=0, m_valid=0, cnt=0, and the counter of REQ-032 to 0.
REQ-029 rst SHALL take priority over every other input; reset mid-BUSY/OUT SHALL abort the block with no output, and the aborted block SHALL NOT be counted.
REQ-030 With rst=1, s_ready SHALL still follow REQ-017 (IDLE after the first edge).

Configuration
REQ-031 Macro AES_CBC_BLKCNT_EN SHALL control the block counter feature.
REQ-032 With the macro defined, the block SHALL add output blk_cnt, 32 bits: count of ciphertext blocks accepted (REQ-023) since the last iv_load or reset, wrapping 0xFFFFFFFF->0.
REQ-033 iv_load SHALL clear blk_cnt to 0.
REQ-034 Without the macro, port blk_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 ECB equivalence: iv_load with key 000102030405060708090a0b0c0d0e0f and IV 0, then plaintext 00112233445566778899aabbccddeeff -> m_data=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-036 SP800-38A CBC: key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f, P1 6bc1bee22e409f96e93d7e117393172a -> 7649abac8119b246cee98e9b12e9197d; P2 ae2d8a571e03ac9c9eb76fac45af8e51 -> 5086cb9b507219ee95db113a917678b2; blk_cnt=2 if enabled.
REQ-037 Backpressure: hold m_ready=0 for 10 cycles in OUT -> m_data stable, s_ready=0, and iv_load ignored (chain=C1 afterwards).
REQ-038 Simultaneous iv_load and s_valid in IDLE -> s_ready=0, IV loaded, block accepted the next cycle.
REQ-039 Latency: CORE_LAT=1 and CORE_LAT=4 -> m_valid rises exactly 2 and 5 cycles after handshake.
REQ-040 Reset in BUSY -> next cycle m_valid=0, core_in=0, s_ready=1, and no output is produced for the aborted block.
